// File: rtl/regfile_writer.sv
// Register file of 16 WIDTH-bit registers written through a 2-entry in-order write buffer.
// reg0 is hardwired to zero; writes to it are drained normally and discarded.
module regfile_writer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             freeze,
    input  logic             clr,
    output logic             pending,
    output logic [WIDTH-1:0] reg0,
    output logic [WIDTH-1:0] reg1,
    output logic [WIDTH-1:0] reg2,
    output logic [WIDTH-1:0] reg3,
    output logic [WIDTH-1:0] reg4,
    output logic [WIDTH-1:0] reg5,
    output logic [WIDTH-1:0] reg6,
    output logic [WIDTH-1:0] reg7,
    output logic [WIDTH-1:0] reg8,
    output logic [WIDTH-1:0] reg9,
    output logic [WIDTH-1:0] reg10,
    output logic [WIDTH-1:0] reg11,
    output logic [WIDTH-1:0] reg12,
    output logic [WIDTH-1:0] reg13,
    output logic [WIDTH-1:0] reg14,
    output logic [WIDTH-1:0] reg15
);

    // Buffer state; pointers are one bit wide since only a depth of two is supported.
    logic [3:0]       buf_addr_q [2];
    logic [WIDTH-1:0] buf_data_q [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;

    logic [WIDTH-1:0] regs_q [1:15];

    logic             accept;
    logic             drain;
    logic [3:0]       head_addr;
    logic [WIDTH-1:0] head_data;
    logic [15:1]      wr_en;

    assign wr_ready = ({30'd0, count_q} < DEPTH);
    assign pending  = (count_q != 2'd0);

    assign head_addr = buf_addr_q[rd_ptr_q];
    assign head_data = buf_data_q[rd_ptr_q];

    always_comb begin
        accept = wr_valid && wr_ready && !clr;
        drain  = (count_q != 2'd0) && !freeze && !clr;
    end

    // Head decode: at most one register enabled; address 0 enables nothing.
    always_comb begin
        wr_en = '0;
        for (int i = 1; i < 16; i++) begin
            wr_en[i] = drain && (head_addr == 4'(i));
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            rd_ptr_d = rd_ptr_q ^ drain;
            wr_ptr_d = wr_ptr_q ^ accept;
            count_d  = count_q + {1'b0, accept} - {1'b0, drain};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: it is only read while count marks it valid.
    always_ff @(posedge clock) begin
        if (accept) begin
            buf_addr_q[wr_ptr_q] <= wr_addr;
            buf_data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 1; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 16; i++) begin
                if (wr_en[i]) begin
                    regs_q[i] <= head_data;
                end
            end
        end
    end

    assign reg0  = '0;
    assign reg1  = regs_q[1];
    assign reg2  = regs_q[2];
    assign reg3  = regs_q[3];
    assign reg4  = regs_q[4];
    assign reg5  = regs_q[5];
    assign reg6  = regs_q[6];
    assign reg7  = regs_q[7];
    assign reg8  = regs_q[8];
    assign reg9  = regs_q[9];
    assign reg10 = regs_q[10];
    assign reg11 = regs_q[11];
    assign reg12 = regs_q[12];
    assign reg13 = regs_q[13];
    assign reg14 = regs_q[14];
    assign reg15 = regs_q[15];

endmodule

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer: accepted writes go into a scoreboard queue and are
// popped and compared against the register outputs when they are expected to commit.
module tb_regfile_writer;

    localparam int unsigned WIDTH = 32;

    typedef struct packed {
        logic [3:0]       addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic             clock;
    logic             reset;
    logic             wr_valid;
    logic             wr_ready;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             freeze;
    logic             clr;
    logic             pending;
    logic [WIDTH-1:0] dut_regs [16];
    logic [WIDTH-1:0] mregs [16];

    wr_t sb_q [$];
    int  errors = 0;
    int  checks = 0;

    regfile_writer #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .freeze   (freeze),
        .clr      (clr),
        .pending  (pending),
        .reg0     (dut_regs[0]),
        .reg1     (dut_regs[1]),
        .reg2     (dut_regs[2]),
        .reg3     (dut_regs[3]),
        .reg4     (dut_regs[4]),
        .reg5     (dut_regs[5]),
        .reg6     (dut_regs[6]),
        .reg7     (dut_regs[7]),
        .reg8     (dut_regs[8]),
        .reg9     (dut_regs[9]),
        .reg10    (dut_regs[10]),
        .reg11    (dut_regs[11]),
        .reg12    (dut_regs[12]),
        .reg13    (dut_regs[13]),
        .reg14    (dut_regs[14]),
        .reg15    (dut_regs[15])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_write(input logic [3:0] a, input logic [WIDTH-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        sb_q.push_back({a, d});
    endtask

    // Oldest expected commit; also updates the bench's model of the register file.
    function automatic wr_t retire();
        wr_t e;
        e = sb_q.pop_front();
        if (e.addr != 4'd0) mregs[e.addr] = e.data;
        return e;
    endfunction

    task automatic model_clear();
        sb_q.delete();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        freeze   = 1'b0;
        clr      = 1'b0;
        model_clear();
        #12;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_regs[i] !== '0) begin
                errors++;
                $display("FAIL reset_reg%0d got=%h want=0", i, dut_regs[i]);
            end
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending got=%b want=0", pending);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready got=%b want=1", wr_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        wr_t e;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got=%b want=1", wr_ready);
        end
        push_write(4'd5, 32'hDEADBEEF);
        tick();
        wr_valid = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL single_pending_hi got=%b want=1", pending);
        end
        checks++;
        if (dut_regs[5] !== 32'h0) begin
            errors++;
            $display("FAIL single_no_bypass got=%h want=0", dut_regs[5]);
        end
        tick();
        e = retire();
        checks++;
        if (dut_regs[e.addr] !== e.data) begin
            errors++;
            $display("FAIL single_commit reg%0d got=%h want=%h", e.addr, dut_regs[e.addr], e.data);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL single_pending_lo got=%b want=0", pending);
        end
    endtask

    task automatic test_freeze();
        wr_t e;
        freeze = 1'b1;
        push_write(4'd3, 32'h1);
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL freeze_ready1 got=%b want=1", wr_ready);
        end
        push_write(4'd4, 32'h2);
        tick();
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL freeze_full got=%b want=0", wr_ready);
        end
        // Third request presented while full: must be ignored.
        wr_addr = 4'd7;
        wr_data = 32'h3;
        tick();
        checks++;
        if (dut_regs[3] !== mregs[3]) begin
            errors++;
            $display("FAIL freeze_stalled reg3 got=%h want=%h", dut_regs[3], mregs[3]);
        end
        freeze = 1'b0;
        tick();
        e = retire();
        checks++;
        if (dut_regs[e.addr] !== e.data) begin
            errors++;
            $display("FAIL freeze_first reg%0d got=%h want=%h", e.addr, dut_regs[e.addr], e.data);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL freeze_ready2 got=%b want=1", wr_ready);
        end
        push_write(4'd7, 32'h3);
        tick();
        wr_valid = 1'b0;
        e = retire();
        checks++;
        if (dut_regs[e.addr] !== e.data) begin
            errors++;
            $display("FAIL freeze_second reg%0d got=%h want=%h", e.addr, dut_regs[e.addr], e.data);
        end
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL freeze_pending got=%b want=1", pending);
        end
        tick();
        e = retire();
        checks++;
        if (dut_regs[e.addr] !== e.data) begin
            errors++;
            $display("FAIL freeze_third reg%0d got=%h want=%h", e.addr, dut_regs[e.addr], e.data);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL freeze_drained got=%b want=0", pending);
        end
    endtask

    task automatic test_zero_reg();
        wr_t e;
        push_write(4'd0, 32'hFFFFFFFF);
        tick();
        wr_valid = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL zero_pending_hi got=%b want=1", pending);
        end
        tick();
        e = retire();
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL zero_pending_lo got=%b want=0", pending);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_regs[i] !== mregs[i]) begin
                errors++;
                $display("FAIL zero_reg%0d got=%h want=%h", i, dut_regs[i], mregs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        wr_t e;
        push_write(4'd9, 32'hAAAA);
        tick();
        push_write(4'd9, 32'h5555);
        tick();
        wr_valid = 1'b0;
        e = retire();
        checks++;
        if (dut_regs[9] !== e.data) begin
            errors++;
            $display("FAIL b2b_first got=%h want=%h", dut_regs[9], e.data);
        end
        tick();
        e = retire();
        checks++;
        if (dut_regs[9] !== e.data) begin
            errors++;
            $display("FAIL b2b_last got=%h want=%h", dut_regs[9], e.data);
        end
    endtask

    task automatic test_clear();
        freeze = 1'b1;
        push_write(4'd2, 32'h11);
        tick();
        push_write(4'd6, 32'h22);
        tick();
        wr_addr = 4'd8;
        wr_data = 32'h33;
        clr     = 1'b1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready_during got=%b want=0", wr_ready);
        end
        tick();
        clr      = 1'b0;
        wr_valid = 1'b0;
        freeze   = 1'b0;
        model_clear();
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL clear_pending got=%b want=0", pending);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready got=%b want=1", wr_ready);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_regs[i] !== mregs[i]) begin
                errors++;
                $display("FAIL clear_reg%0d got=%h want=%h", i, dut_regs[i], mregs[i]);
            end
        end
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_regs[i] !== mregs[i]) begin
                errors++;
                $display("FAIL clear_lost_reg%0d got=%h want=%h", i, dut_regs[i], mregs[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        wr_t e;
        push_write(4'd1, 32'h77);
        tick();
        wr_valid = 1'b0;
        tick();
        e = retire();
        checks++;
        if (dut_regs[1] !== e.data) begin
            errors++;
            $display("FAIL areset_preload got=%h want=%h", dut_regs[1], e.data);
        end
        freeze = 1'b1;
        push_write(4'd10, 32'hA0);
        tick();
        push_write(4'd11, 32'hB0);
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_full got=%b want=0", wr_ready);
        end
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_regs[i] !== mregs[i]) begin
                errors++;
                $display("FAIL areset_reg%0d got=%h want=%h", i, dut_regs[i], mregs[i]);
            end
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL areset_pending got=%b want=0", pending);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_ready got=%b want=1", wr_ready);
        end
        freeze = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (dut_regs[10] !== 32'h0 || dut_regs[11] !== 32'h0) begin
            errors++;
            $display("FAIL areset_discard reg10=%h reg11=%h want=0", dut_regs[10], dut_regs[11]);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL areset_after_pending got=%b want=0", pending);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_freeze();
        test_zero_reg();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
